// File: rtl/sys_array_feeder.sv
// sys_array_feeder: input skew stage for a systolic array.
// Accepts one ARRAY_L-lane vector per handshake, delays lane i by i cycles
// and drives the diagonal wavefront plus per-lane valid tags to the array.
// One matrix is framed per start command; the skew pipeline is drained
// before done pulses.
//
// Optional feature macro: FEEDER_OUT_REG_EN
//   defined   -> extra register on input_module/lane_tag, flush one cycle longer
//   undefined -> delay-line tails drive the outputs directly
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; delay lines drain zeros
// S_STREAM | in_ready high; handshakes push data, otherwise bubbles
// S_FLUSH  | pushing zeros until the last vector leaves the last lane

module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_L    = 4,
  parameter int COUNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [COUNT_W-1:0]            num_vectors,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*ARRAY_L-1:0] in_data,
  output logic [DATA_WIDTH*ARRAY_L-1:0] input_module,
  output logic [ARRAY_L-1:0]            lane_tag,
  output logic                          busy,
  output logic                          done
);

`ifdef FEEDER_OUT_REG_EN
  localparam int FLUSH_LEN = ARRAY_L;
`else
  localparam int FLUSH_LEN = ARRAY_L - 1;
`endif
  // Keep the counter at least one bit wide even for a single-lane array.
  localparam int FCNT_W = (FLUSH_LEN < 1) ? 1 : $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t                          state_q;
  state_t                          state_nxt;
  logic [COUNT_W-1:0]              remaining_q;
  logic [FCNT_W-1:0]               flush_cnt_q;
  logic                            hs;
  logic [DATA_WIDTH*ARRAY_L-1:0]   head_data;
  logic                            head_tag;
  logic [DATA_WIDTH*ARRAY_L-1:0]   tail_data;
  logic [ARRAY_L-1:0]              tail_tag;

  // Handshake derives from state only, so in_ready never depends on in_valid.
  assign hs        = in_valid && (state_q == S_STREAM);
  assign head_data = hs ? in_data : '0;
  assign head_tag  = hs;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_vectors == '0) ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs && (remaining_q == COUNT_W'(1))) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_FLUSH: begin
        busy = 1'b1;
        done = (flush_cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Vector counter: latched on an accepted start, counts handshakes down to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      remaining_q <= num_vectors;
    end else if (hs && (remaining_q != '0)) begin
      remaining_q <= remaining_q - COUNT_W'(1);
    end
  end

  // Flush timer: loaded on entry to FLUSH, terminal count at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
    end else if ((state_q != S_FLUSH) && (state_nxt == S_FLUSH)) begin
      flush_cnt_q <= FCNT_W'(FLUSH_LEN);
    end else if ((state_q == S_FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - FCNT_W'(1);
    end
  end

  // Per-lane delay lines; lane g is g+1 registers deep, tags ride alongside.
  for (genvar g = 0; g < ARRAY_L; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_sr [0:g];
    logic                  tag_sr  [0:g];

    // Head written every cycle (data, bubble or flush zero); stages shift on.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k <= g; k++) begin
          data_sr[k] <= '0;
          tag_sr[k]  <= 1'b0;
        end
      end else begin
        data_sr[0] <= head_data[DATA_WIDTH*g +: DATA_WIDTH];
        tag_sr[0]  <= head_tag;
        for (int k = 1; k <= g; k++) begin
          data_sr[k] <= data_sr[k-1];
          tag_sr[k]  <= tag_sr[k-1];
        end
      end
    end

    assign tail_data[DATA_WIDTH*g +: DATA_WIDTH] = data_sr[g];
    assign tail_tag[g]                           = tag_sr[g];
  end

`ifdef FEEDER_OUT_REG_EN
  // Output retiming register; adds one cycle to every lane uniformly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      input_module <= '0;
      lane_tag     <= '0;
    end else begin
      input_module <= tail_data;
      lane_tag     <= tail_tag;
    end
  end
`else
  assign input_module = tail_data;
  assign lane_tag     = tail_tag;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder in its default build (ARRAY_L=4,
// DATA_WIDTH=8, output register disabled). Inputs change and outputs are
// sampled 1 time unit after each rising edge.

module tb_sys_array_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  num_vectors;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] input_module;
  logic [3:0]  lane_tag;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] V0   = 32'h0403_0201;
  localparam logic [31:0] V1   = 32'h0807_0605;
  localparam logic [31:0] V2   = 32'h0C0B_0A09;
  localparam logic [31:0] V3   = 32'h100F_0E0D;
  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  sys_array_feeder #(
    .DATA_WIDTH (8),
    .ARRAY_L    (4),
    .COUNT_W    (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_vectors  (num_vectors),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .input_module (input_module),
    .lane_tag     (lane_tag),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Lane packing helper: lane 0 in the low byte.
  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    pk = {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", nm, obs, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [31:0] ed, input logic [3:0] et,
                           input logic edn, input logic eb, input logic er);
    chk32({nm, ".data"}, input_module, ed);
    chk32({nm, ".tag"}, {28'b0, lane_tag}, {28'b0, et});
    chk1({nm, ".done"}, done, edn);
    chk1({nm, ".busy"}, busy, eb);
    chk1({nm, ".ready"}, in_ready, er);
  endtask

  // Drive one cycle of input, clock it in, then check the resulting outputs.
  task automatic step(input string nm, input logic vld, input logic [31:0] dat,
                      input logic [31:0] ed, input logic [3:0] et,
                      input logic edn, input logic eb, input logic er);
    in_valid = vld;
    in_data  = dat;
    @(posedge clk);
    #1;
    check_all(nm, ed, et, edn, eb, er);
  endtask

  task automatic issue_start(input string nm, input logic [7:0] n, input logic exp_rdy);
    start       = 1'b1;
    num_vectors = n;
    in_valid    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_all(nm, 32'h0, 4'b0000, 1'b0, 1'b1, exp_rdy);
  endtask

  // Four back-to-back vectors; optionally a start with num_vectors=9 during STREAM.
  task automatic run_full(input string p, input bit restart);
    issue_start({p, ".start"}, 8'd4, 1'b1);
    step({p, ".c0"}, 1'b1, V0, pk(1, 0, 0, 0),     4'b0001, 1'b0, 1'b1, 1'b1);
    if (restart) begin
      start       = 1'b1;
      num_vectors = 8'd9;
    end
    step({p, ".c1"}, 1'b1, V1, pk(5, 2, 0, 0),     4'b0011, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step({p, ".c2"}, 1'b1, V2, pk(9, 6, 3, 0),     4'b0111, 1'b0, 1'b1, 1'b1);
    step({p, ".c3"}, 1'b1, V3, pk(13, 10, 7, 4),   4'b1111, 1'b0, 1'b1, 1'b0);
    step({p, ".c4"}, 1'b1, JUNK, pk(0, 14, 11, 8), 4'b1110, 1'b0, 1'b1, 1'b0);
    step({p, ".c5"}, 1'b1, JUNK, pk(0, 0, 15, 12), 4'b1100, 1'b0, 1'b1, 1'b0);
    step({p, ".c6"}, 1'b1, JUNK, pk(0, 0, 0, 16),  4'b1000, 1'b1, 1'b1, 1'b0);
    step({p, ".c7"}, 1'b1, JUNK, 32'h0,            4'b0000, 1'b0, 1'b0, 1'b0);
    step({p, ".c8"}, 1'b0, JUNK, 32'h0,            4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held for 80 time units with start and in_valid asserted.
    reset_n     = 1'b0;
    start       = 1'b1;
    num_vectors = 8'd4;
    in_valid    = 1'b1;
    in_data     = JUNK;
    #3;
    check_all("rst.t3", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
      check_all("rst.hold", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    #14;
    start    = 1'b0;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst.after", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Full 4x4 frame.
    run_full("full", 1'b0);

    // One bubble between vectors 2 and 3.
    issue_start("bub.start", 8'd4, 1'b1);
    step("bub.c0", 1'b1, V0,   pk(1, 0, 0, 0),     4'b0001, 1'b0, 1'b1, 1'b1);
    step("bub.c1", 1'b1, V1,   pk(5, 2, 0, 0),     4'b0011, 1'b0, 1'b1, 1'b1);
    step("bub.c2", 1'b0, JUNK, pk(0, 6, 3, 0),     4'b0110, 1'b0, 1'b1, 1'b1);
    step("bub.c3", 1'b1, V2,   pk(9, 0, 7, 4),     4'b1101, 1'b0, 1'b1, 1'b1);
    step("bub.c4", 1'b1, V3,   pk(13, 10, 0, 8),   4'b1011, 1'b0, 1'b1, 1'b0);
    step("bub.c5", 1'b0, JUNK, pk(0, 14, 11, 0),   4'b0110, 1'b0, 1'b1, 1'b0);
    step("bub.c6", 1'b0, JUNK, pk(0, 0, 15, 12),   4'b1100, 1'b0, 1'b1, 1'b0);
    step("bub.c7", 1'b0, JUNK, pk(0, 0, 0, 16),    4'b1000, 1'b1, 1'b1, 1'b0);
    step("bub.c8", 1'b0, JUNK, 32'h0,              4'b0000, 1'b0, 1'b0, 1'b0);

    // Zero-length frame; in_valid held high must never be accepted.
    issue_start("zero.start", 8'd0, 1'b0);
    step("zero.c1", 1'b1, JUNK, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("zero.c2", 1'b1, JUNK, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("zero.c3", 1'b1, JUNK, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("zero.c4", 1'b1, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("zero.c5", 1'b0, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // start during STREAM is ignored.
    run_full("restart", 1'b1);

    // Asynchronous reset after two accepted vectors.
    issue_start("mid.start", 8'd4, 1'b1);
    step("mid.c0", 1'b1, V0, pk(1, 0, 0, 0), 4'b0001, 1'b0, 1'b1, 1'b1);
    step("mid.c1", 1'b1, V1, pk(5, 2, 0, 0), 4'b0011, 1'b0, 1'b1, 1'b1);
    in_data = V2;
    reset_n = 1'b0;
    #1;
    check_all("mid.rst", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("mid.rst_hold", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step("mid.q0", 1'b0, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("mid.q1", 1'b0, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("mid.q2", 1'b0, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("mid.q3", 1'b0, JUNK, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_full("after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_array_feeder.md
# sys_array_feeder

Input skew stage placed directly upstream of `sys_array_basic`. It accepts one ARRAY_L-element input vector per valid/ready handshake, delays lane i by i cycles, and drives the diagonal wavefront onto the array's `input_module` bus. Unaccepted slots are filled with zeros, and per-lane tag bits mark which array inputs carry real data. It frames one matrix per `start` command and drains the skew pipeline before signalling `done`.

## Interface
- DATA_WIDTH, 8, element width in bits
- ARRAY_L, 4, number of array rows (lanes)
- COUNT_W, 8, width of the vector counter
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command; sampled only in IDLE
- num_vectors  in  COUNT_W  number of vectors in the matrix; sampled with `start`
- in_valid  in  1  `in_data` holds a vector
- in_ready  out  1  feeder accepts a vector this cycle
- in_data  in  DATA_WIDTH*ARRAY_L  lane i is at [DATA_WIDTH*i +: DATA_WIDTH]
- input_module  out  DATA_WIDTH*ARRAY_L  skewed data to the array, same lane packing
- lane_tag  out  ARRAY_L  bit i is 1 when lane i of `input_module` carries accepted data
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- Every output resets to 0. State resets to IDLE, and all delay-line stages and tags reset to 0.
- State machine:
  - IDLE: a `start` pulse latches `num_vectors` into `remaining`. If `remaining` is 0, go to FLUSH; otherwise go to STREAM.
  - STREAM: `in_ready` = 1. A handshake (in_valid & in_ready) pushes `in_data` into the lane heads with tag 1 and decrements `remaining`.
    - If there is no handshake, a zero vector with tag 0 is pushed instead (a bubble). The pipeline never stalls, because the array free-runs.
    - When the handshake that brings `remaining` to 0 occurs, go to FLUSH.
  - FLUSH: `in_ready` = 0. Zeros with tag 0 are pushed every cycle. A down-counter runs for ARRAY_L-1 cycles (plus 1 when FEEDER_OUT_REG_EN is defined). At terminal count, pulse `done` and return to IDLE.
- Lane i is a shift register of depth i+1. The head register is written every cycle and the tail drives `input_module` lane i.
- Tags travel through an identical delay line, so lane_tag[i] is exactly aligned with lane i data.
- Counter arithmetic:
  - `remaining` never underflows.
  - `start` while busy is ignored.
  - `in_valid` outside STREAM is ignored; the upstream holds its data.
- Zero-length frame (num_vectors = 0): no data is pushed and `done` still pulses. The pulse comes ARRAY_L-1 (+1 with macro) cycles after the cycle following `start`.
- Asynchronous reset mid-frame: everything clears immediately. No `done` is issued, and the partial frame is lost.

## Timing
- A vector accepted at rising edge t appears on lane i at edge t+1+i. With FEEDER_OUT_REG_EN it appears at t+2+i.
- Back-to-back handshakes produce contiguous diagonals. A bubble shifts all later data in all lanes by one cycle, so alignment is preserved.
- `done` is asserted in the cycle in which lane ARRAY_L-1 presents the last accepted element.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Configuration
- FEEDER_OUT_REG_EN defined:
  - An extra register stage sits on `input_module` and `lane_tag`.
  - Every lane's latency grows by 1.
  - FLUSH grows by 1 cycle.
- FEEDER_OUT_REG_EN undefined: the delay-line tails drive the outputs directly.

## Test plan
- **Reset:** hold reset_n=0 for 80 time units with `in_valid`=1 and `start`=1. Required response: all outputs stay 0 and state remains IDLE.
- **Full 4×4 frame:** ARRAY_L=4, num_vectors=4, vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} sent back-to-back. Required response:
  - Lane 0 shows 1, 5, 9, 13 starting at t+1.
  - Lane 3 shows 4, 8, 12, 16 starting at t+4.
  - `done` pulses with lane 3 = 16, then all lanes are 0 with tags 0.
- **Bubble insertion:** deassert `in_valid` for one cycle between vectors 2 and 3. Required response: every lane shows one zero with tag 0 in that slot, and `done` is delayed by exactly 1 cycle.
- **Zero length:** start with num_vectors=0. Required response: `in_ready` is never 1, `done` pulses after 3 cycles, and `busy` drops.
- **Busy restart:** assert `start` during STREAM with num_vectors=9. Required response: the command is ignored and the frame ends after the original 4 vectors.
- **Reset mid-frame:** pull reset_n low after 2 of 4 vectors are accepted. Required response: outputs clear immediately, no `done` is issued, and a new frame then runs correctly.
